// File: rtl/data_mem_sized.sv
// data_mem_sized: byte/half/word data memory behind a valid/ready request port.
// Loads are sign- or zero-extended, and accesses are checked for alignment, size and range.
// Each access produces a one-cycle response pulse READ_LAT cycles after it is accepted.
// Only one access is outstanding at a time.
// Optional feature: define DMEM_PARITY_EN to add one even-parity bit per byte lane.
// Loads then fault on a parity mismatch in any lane they touch.
module data_mem_sized #(
   parameter int ADDR_W      = 32,
   parameter int DEPTH_WORDS = 1024,
   parameter int READ_LAT    = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_fault
);

   localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_lat
      $error("data_mem_sized: READ_LAT must be in 1..4");
   end

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t state_q, state_d;
   logic [1:0] cnt_q, cnt_d;

   logic [3:0][7:0] mem [DEPTH_WORDS];

   // Byte lanes touched by an access of the given size at the given offset.
   function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
      case (size)
         2'b00:   return 4'b0001 << off;
         2'b01:   return off[1] ? 4'b1100 : 4'b0011;
         2'b10:   return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

   // Replicate right-aligned store data so that every candidate lane sees it.
   function automatic logic [3:0][7:0] store_lanes(input logic [1:0] size, input logic [31:0] wd);
      case (size)
         2'b00:   return {4{wd[7:0]}};
         2'b01:   return {2{wd[15:0]}};
         default: return wd;
      endcase
   endfunction

   // Pick the addressed lane(s) and widen them to 32 bits.
   function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] off,
                                               input logic [1:0] size, input logic uns);
      logic [31:0]        sh;
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic signed [31:0] sx;
      sh = word >> {off, 3'b000};
      b  = sh[7:0];
      h  = sh[15:0];
      case (size)
         2'b00: begin
            sx = b;
            return uns ? {24'd0, sh[7:0]} : sx;
         end
         2'b01: begin
            sx = h;
            return uns ? {16'd0, sh[15:0]} : sx;
         end
         2'b10:   return word;
         default: return 32'd0;
      endcase
   endfunction

   logic                  accept;
   logic [ADDR_W-3:0]     widx;
   logic [IDX_W-1:0]      idx;
   logic                  align_bad;
   logic                  range_bad;
   logic                  fault_now;
   logic [3:0]            be;
   logic [3:0][7:0]       wlanes;

   assign accept    = req_valid & req_ready & ~rst;
   assign widx      = req_addr[ADDR_W-1:2];
   assign idx       = req_addr[IDX_W+1:2];
   assign range_bad = (widx >= (ADDR_W-2)'(DEPTH_WORDS));
   assign align_bad = (req_size == 2'b11) ||
                      (req_size == 2'b01 && req_addr[0]) ||
                      (req_size == 2'b10 && req_addr[1:0] != 2'b00);
   assign fault_now = align_bad | range_bad;
   assign be        = lane_mask(req_size, req_addr[1:0]);
   assign wlanes    = store_lanes(req_size, req_wdata);

   // Captured access: read word and the fields needed to shape the response.
   logic [3:0][7:0] word_p1;
   logic [1:0]      off_p1;
   logic [1:0]      size_p1;
   logic            uns_p1;
   logic            fault_p1;
   logic            par_bad;

`ifdef DMEM_PARITY_EN
   logic [3:0] par_mem [DEPTH_WORDS];
   logic [3:0] par_p1;
   logic [3:0] chk_mask_p1;

   // Store lanes and their parity bits; stores never read the old word.
   always_ff @(posedge clk) begin
      if (accept && req_we && !fault_now) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
               mem[idx][i]     <= wlanes[i];
               par_mem[idx][i] <= ^wlanes[i];
            end
         end
      end
   end

   // Capture parity bits alongside the word; stores and faults check no lanes.
   always_ff @(posedge clk) begin
      if (accept) begin
         par_p1      <= fault_now ? 4'b0000 : par_mem[idx];
         chk_mask_p1 <= (req_we || fault_now) ? 4'b0000 : be;
      end
   end

   assign par_bad = |((par_p1 ^ {^word_p1[3], ^word_p1[2], ^word_p1[1], ^word_p1[0]}) & chk_mask_p1);
`else
   // Store lanes; unwritten lanes keep their contents.
   always_ff @(posedge clk) begin
      if (accept && req_we && !fault_now) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[idx][i] <= wlanes[i];
         end
      end
   end

   assign par_bad = 1'b0;
`endif

   // ---- stage boundary: request accepted -> captured access ----
   // Capture the RAM word at the accept edge so the response can be shaped later.
   always_ff @(posedge clk) begin
      if (accept) begin
         word_p1  <= (req_we || fault_now) ? '0 : mem[idx];
         off_p1   <= req_addr[1:0];
         size_p1  <= req_size;
         uns_p1   <= req_unsigned;
         fault_p1 <= fault_now;
      end
   end

   // State register and latency counter; reset drops any access in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state and handshake outputs.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               cnt_d   = 2'(READ_LAT - 1);
               state_d = (READ_LAT > 1) ? S_WAIT : S_RESP;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 2'd1;
            if (cnt_d == 2'd0) state_d = S_RESP;
         end
         S_RESP: begin
            resp_valid = 1'b1;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ---- stage boundary: captured access -> response ----
   assign resp_fault = resp_valid & (fault_p1 | par_bad);
   assign resp_rdata = (resp_valid && !resp_fault) ? load_extend(word_p1, off_p1, size_p1, uns_p1)
                                                   : 32'd0;

endmodule

// File: tb/tb_data_mem_sized.sv
// Scoreboard bench for data_mem_sized: two instances, READ_LAT=1 and READ_LAT=3.
// The expected responses come from a byte-array reference model.
module tb_data_mem_sized;

   localparam int DEPTH  = 256;
   localparam int NBYTES = 4 * DEPTH;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst          [2];
   logic        req_valid    [2];
   logic        req_ready    [2];
   logic        req_we       [2];
   logic [31:0] req_addr     [2];
   logic [1:0]  req_size     [2];
   logic        req_unsigned [2];
   logic [31:0] req_wdata    [2];
   logic        resp_valid   [2];
   logic [31:0] resp_rdata   [2];
   logic        resp_fault   [2];

   data_mem_sized #(.ADDR_W(32), .DEPTH_WORDS(DEPTH), .READ_LAT(1)) u_lat1 (
      .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_we(req_we[0]), .req_addr(req_addr[0]), .req_size(req_size[0]),
      .req_unsigned(req_unsigned[0]), .req_wdata(req_wdata[0]),
      .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_fault(resp_fault[0]));

   data_mem_sized #(.ADDR_W(32), .DEPTH_WORDS(DEPTH), .READ_LAT(3)) u_lat3 (
      .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_we(req_we[1]), .req_addr(req_addr[1]), .req_size(req_size[1]),
      .req_unsigned(req_unsigned[1]), .req_wdata(req_wdata[1]),
      .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_fault(resp_fault[1]));

   typedef struct {
      logic [31:0] rdata;
      logic        fault;
      int          due;
   } exp_t;

   exp_t       q0[$];
   exp_t       q1[$];
   logic [7:0] mdl [2][NBYTES];
   int         total = 0;
   int         bad   = 0;
   int         cyc   = 0;
   bit         inject_fault = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
      end
   endfunction

   function automatic int lat(input int u);
      return (u == 0) ? 1 : 3;
   endfunction

   function automatic int qsize(input int u);
      return (u == 0) ? q0.size() : q1.size();
   endfunction

   function automatic void qpush(input int u, input exp_t e);
      if (u == 0) q0.push_back(e);
      else        q1.push_back(e);
   endfunction

   function automatic exp_t qpop(input int u);
      if (u == 0) return q0.pop_front();
      return q1.pop_front();
   endfunction

   // Reference model: little-endian byte array, access rules applied directly.
   function automatic void model_op(input int u, input logic we, input logic [31:0] a,
                                    input logic [1:0] sz, input logic uns, input logic [31:0] wd,
                                    output logic [31:0] rd, output logic f);
      int n;
      logic [31:0] v;
      n  = 1 << sz;
      f  = (sz == 2'd3) || (a % n != 0) || (a >= NBYTES);
      rd = 32'd0;
      if (!f) begin
         if (we) begin
            for (int i = 0; i < n; i++) mdl[u][a + i] = wd[8*i +: 8];
         end else begin
            v = 32'd0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = mdl[u][a + i];
            if (!uns && n < 4 && v[8*n - 1]) begin
               for (int b = 8 * n; b < 32; b++) v[b] = 1'b1;
            end
            rd = v;
         end
      end
   endfunction

   function automatic void mon(input int u);
      exp_t e;
      if (rst[u]) return;
      if (resp_valid[u]) begin
         if (qsize(u) == 0) begin
            chk($sformatf("u%0d_resp_expected", u), 32'(qsize(u)), 32'd1);
         end else begin
            e = qpop(u);
            chk($sformatf("u%0d_rdata", u), resp_rdata[u], e.rdata);
            chk($sformatf("u%0d_fault", u), 32'(resp_fault[u]), 32'(e.fault));
            chk($sformatf("u%0d_latency_cycle", u), 32'(cyc), 32'(e.due));
            chk($sformatf("u%0d_ready_in_resp", u), 32'(req_ready[u]), 32'd0);
         end
      end else begin
         chk($sformatf("u%0d_idle_rdata", u), resp_rdata[u], 32'd0);
         chk($sformatf("u%0d_idle_fault", u), 32'(resp_fault[u]), 32'd0);
      end
   endfunction

   always @(negedge clk) mon(0);
   always @(negedge clk) mon(1);

   task automatic send(input int u, input logic we, input logic [31:0] a, input logic [1:0] sz,
                       input logic uns, input logic [31:0] wd, input bit expect_resp,
                       output int acc);
      logic r;
      bit   got;
      exp_t e;
      req_we[u]       = we;
      req_addr[u]     = a;
      req_size[u]     = sz;
      req_unsigned[u] = uns;
      req_wdata[u]    = wd;
      req_valid[u]    = 1'b1;
      got = 1'b0;
      acc = -1;
      for (int k = 0; k < 20 && !got; k++) begin
         r = req_ready[u];
         @(posedge clk);
         #1;
         if (r) got = 1'b1;
      end
      req_valid[u] = 1'b0;
      chk($sformatf("u%0d_accept", u), 32'(got), 32'd1);
      if (got) begin
         acc = cyc;
         model_op(u, we, a, sz, uns, wd, e.rdata, e.fault);
         if (inject_fault) begin
            e.fault = 1'b1;
            e.rdata = 32'd0;
         end
         e.due = cyc + lat(u) - 1;
         if (expect_resp) qpush(u, e);
      end
   endtask

   task automatic drain(input int u);
      exp_t junk;
      for (int k = 0; k < lat(u) + 4 && qsize(u) != 0; k++) begin
         @(posedge clk);
         #1;
      end
      chk($sformatf("u%0d_resp_arrived", u), 32'(qsize(u)), 32'd0);
      while (qsize(u) != 0) junk = qpop(u);
   endtask

   task automatic op(input int u, input logic we, input logic [31:0] a, input logic [1:0] sz,
                     input logic uns, input logic [31:0] wd);
      int acc;
      send(u, we, a, sz, uns, wd, 1'b1, acc);
      drain(u);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int a0, a1;
      logic [1:0]  sz;
      logic [31:0] addr;

      for (int u = 0; u < 2; u++) begin
         rst[u] = 1'b1; req_valid[u] = 1'b0; req_we[u] = 1'b0; req_addr[u] = 32'd0;
         req_size[u] = 2'd0; req_unsigned[u] = 1'b0; req_wdata[u] = 32'd0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int u = 0; u < 2; u++) begin
         chk($sformatf("u%0d_rst_ready", u), 32'(req_ready[u]), 32'd1);
         chk($sformatf("u%0d_rst_valid", u), 32'(resp_valid[u]), 32'd0);
         chk($sformatf("u%0d_rst_rdata", u), resp_rdata[u], 32'd0);
         chk($sformatf("u%0d_rst_fault", u), 32'(resp_fault[u]), 32'd0);
         rst[u] = 1'b0;
      end
      @(posedge clk);
      #1;

      // Word store, extension loads, partial stores, faults on the READ_LAT=1 instance.
      op(0, 1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF);
      op(0, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
      op(0, 1'b0, 32'h11, 2'd0, 1'b0, 32'h0);
      op(0, 1'b0, 32'h13, 2'd0, 1'b1, 32'h0);
      op(0, 1'b0, 32'h12, 2'd1, 1'b0, 32'h0);
      op(0, 1'b1, 32'h12, 2'd1, 1'b0, 32'h00001234);
      op(0, 1'b1, 32'h10, 2'd0, 1'b0, 32'h00000055);
      op(0, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
      op(0, 1'b0, 32'h12, 2'd2, 1'b0, 32'h0);
      op(0, 1'b1, 32'h11, 2'd1, 1'b0, 32'hFFFF);
      op(0, 1'b0, 32'h10, 2'd3, 1'b0, 32'h0);
      op(0, 1'b1, 32'h10, 2'd3, 1'b0, 32'h0);
      op(0, 1'b0, 32'(NBYTES), 2'd2, 1'b0, 32'h0);
      op(0, 1'b1, 32'(NBYTES), 2'd2, 1'b0, 32'h77777777);
      op(0, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0);

      // Fill a window of both memories so random loads read defined data.
      for (int u = 0; u < 2; u++) begin
         for (int w = 0; w < 16; w++) op(u, 1'b1, 32'(4 * w), 2'd2, 1'b0, $urandom);
      end

      // Handshake on READ_LAT=3: a request held through WAIT is taken four cycles later.
      send(1, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 1'b1, a0);
      send(1, 1'b0, 32'h11, 2'd0, 1'b0, 32'h0, 1'b1, a1);
      chk("u1_back_to_back_gap", 32'(a1 - a0), 32'd4);
      drain(1);

      // Reset while a store waits: no response, store already written.
      send(1, 1'b1, 32'h20, 2'd2, 1'b0, 32'hA5C3_5A3C, 1'b0, a0);
      rst[1] = 1'b1;
      @(posedge clk);
      #1;
      rst[1] = 1'b0;
      chk("u1_rst_mid_ready", 32'(req_ready[1]), 32'd1);
      chk("u1_rst_mid_valid", 32'(resp_valid[1]), 32'd0);
      repeat (5) @(posedge clk);
      #1;
      op(1, 1'b0, 32'h20, 2'd2, 1'b0, 32'h0);

      // Reset while a load waits.
      send(1, 1'b0, 32'h24, 2'd2, 1'b0, 32'h0, 1'b0, a0);
      rst[1] = 1'b1;
      @(posedge clk);
      #1;
      rst[1] = 1'b0;
      chk("u1_rst_load_ready", 32'(req_ready[1]), 32'd1);
      repeat (5) @(posedge clk);
      #1;
      op(1, 1'b0, 32'h24, 2'd2, 1'b1, 32'h0);

`ifdef DMEM_PARITY_EN
      u_lat3.par_mem[8][1] = ~u_lat3.par_mem[8][1];
      inject_fault = 1'b1;
      op(1, 1'b0, 32'h21, 2'd0, 1'b0, 32'h0);
      inject_fault = 1'b0;
      op(1, 1'b0, 32'h20, 2'd0, 1'b0, 32'h0);
      op(1, 1'b1, 32'h20, 2'd2, 1'b0, 32'h13579BDF);
`endif

      // Random traffic on both instances, sometimes back-to-back.
      for (int u = 0; u < 2; u++) begin
         for (int n = 0; n < 150; n++) begin
            sz   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            addr = ($urandom_range(0, 9) == 0) ? 32'(NBYTES + $urandom_range(0, 255))
                                               : 32'($urandom_range(0, 63));
            send(u, 1'($urandom_range(0, 1)), addr, sz, 1'($urandom_range(0, 1)), $urandom,
                 1'b1, a0);
            if ($urandom_range(0, 1) == 1) drain(u);
         end
         drain(u);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
